// File: rtl/measure_result_avg.sv
// measure_result_avg: block-averages 2^AVG_LOG2 frequency words and max/min
// amplitude pairs, derives peak-to-peak and DC offset, and presents one stable
// frame under a valid/ready handshake. A frequency timeout flags loss of signal.
module measure_result_avg #(
  parameter int unsigned AVG_LOG2    = 3,
  parameter int unsigned TIMEOUT_CYC = 100_000_000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_freq,
  input  logic        i_freq_vld,
  input  logic [11:0] i_max_val,
  input  logic [11:0] i_min_val,
  input  logic        i_amp_vld,
  input  logic        i_rdy,
  output logic [31:0] o_freq_avg,
  output logic [11:0] o_vpp_avg,
  output logic [11:0] o_offset_avg,
  output logic        o_no_signal,
  output logic        o_vld,
  output logic [7:0]  o_drop_cnt
);

  localparam int unsigned N  = 1 << AVG_LOG2;
  localparam int unsigned FW = 32 + AVG_LOG2;
  localparam int unsigned AW = 13 + AVG_LOG2;
  localparam int unsigned CW = AVG_LOG2 + 1;
  localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [0:0] {StCollect, StOutput} state_e;

  state_e r_state, w_state_d;

  logic [FW-1:0]        r_facc;
  logic [AW-1:0]        r_vacc;
  logic signed [AW-1:0] r_oacc;
  logic [CW-1:0]        r_fcnt, r_acnt;
  logic [TW-1:0]        r_tcnt;
  logic                 r_f_done, r_a_done, r_no_sig;

  logic [31:0] r_freq_avg;
  logic [11:0] r_vpp_avg, r_offset_avg;
  logic        r_no_signal, r_vld;
  logic [7:0]  r_drop_cnt;

  logic w_collect, w_transfer, w_handshake;
  logic w_f_acc, w_a_acc, w_f_drop, w_a_drop, w_f_last, w_a_last, w_timeout;

  logic signed [12:0] w_diff, w_sum, w_off;
  logic [11:0]        w_vpp;
  logic [1:0]         w_drop_inc;
  logic [8:0]         w_drop_sum;
  logic [7:0]         w_drop_d;

  // Per-sample peak-to-peak (clamped at 0) and floor-halved midpoint in 13-bit signed
  assign w_diff = $signed({i_max_val[11], i_max_val}) - $signed({i_min_val[11], i_min_val});
  assign w_sum  = $signed({i_max_val[11], i_max_val}) + $signed({i_min_val[11], i_min_val});
  assign w_off  = w_sum >>> 1;
  assign w_vpp  = w_diff[12] ? 12'd0 : w_diff[11:0];

  // Next state, accept/drop decode and timeout detection
  always_comb begin
    w_state_d   = r_state;
    w_collect   = (r_state == StCollect);
    w_transfer  = w_collect && r_f_done && r_a_done;
    w_handshake = (r_state == StOutput) && i_rdy;
    w_f_acc     = i_freq_vld && w_collect && !r_f_done;
    w_a_acc     = i_amp_vld && w_collect && !r_a_done;
    w_f_drop    = i_freq_vld && !w_f_acc;
    w_a_drop    = i_amp_vld && !w_a_acc;
    w_f_last    = w_f_acc && (r_fcnt == CW'(N - 1));
    w_a_last    = w_a_acc && (r_acnt == CW'(N - 1));
    // A strobe in the timeout cycle clears the counter, so the sample always wins
    w_timeout   = w_collect && !r_f_done && !i_freq_vld && (r_tcnt == TW'(TIMEOUT_CYC - 1));
    unique case (r_state)
      StCollect: if (w_transfer) w_state_d = StOutput;
      StOutput:  if (i_rdy) w_state_d = StCollect;
      default:   w_state_d = StCollect;
    endcase
  end

  // Saturating drop count; two drops in one cycle add 2
  always_comb begin
    w_drop_inc = {1'b0, w_f_drop} + {1'b0, w_a_drop};
    w_drop_sum = {1'b0, r_drop_cnt} + {7'd0, w_drop_inc};
    w_drop_d   = w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= StCollect;
    else          r_state <= w_state_d;
  end

  // Accumulators, sample counters, timeout and output frame registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_facc       <= '0;
      r_vacc       <= '0;
      r_oacc       <= '0;
      r_fcnt       <= '0;
      r_acnt       <= '0;
      r_tcnt       <= '0;
      r_f_done     <= 1'b0;
      r_a_done     <= 1'b0;
      r_no_sig     <= 1'b0;
      r_freq_avg   <= '0;
      r_vpp_avg    <= '0;
      r_offset_avg <= '0;
      r_no_signal  <= 1'b0;
      r_vld        <= 1'b0;
      r_drop_cnt   <= '0;
    end else begin
      r_drop_cnt <= w_drop_d;
      if (w_handshake) begin
        r_facc   <= '0;
        r_vacc   <= '0;
        r_oacc   <= '0;
        r_fcnt   <= '0;
        r_acnt   <= '0;
        r_tcnt   <= '0;
        r_f_done <= 1'b0;
        r_a_done <= 1'b0;
        r_no_sig <= 1'b0;
        r_vld    <= 1'b0;
      end else if (w_transfer) begin
        // Shift-by-AVG_LOG2 is a bit slice; for oacc it is the arithmetic (floor) shift
        r_freq_avg   <= r_no_sig ? 32'd0 : r_facc[AVG_LOG2 +: 32];
        r_vpp_avg    <= r_vacc[AVG_LOG2 +: 12];
        r_offset_avg <= r_oacc[AVG_LOG2 +: 12];
        r_no_signal  <= r_no_sig;
        r_vld        <= 1'b1;
      end else begin
        if (w_f_acc) begin
          r_facc <= r_facc + FW'(i_freq);
          r_fcnt <= r_fcnt + CW'(1);
          r_tcnt <= '0;
          if (w_f_last) begin
            r_f_done <= 1'b1;
            r_no_sig <= 1'b0;
          end
        end else if (w_timeout) begin
          r_facc   <= '0;
          r_fcnt   <= '0;
          r_f_done <= 1'b1;
          r_no_sig <= 1'b1;
        end else if (w_collect && !r_f_done) begin
          r_tcnt <= r_tcnt + TW'(1);
        end
        if (w_a_acc) begin
          r_vacc <= r_vacc + AW'(w_vpp);
          r_oacc <= r_oacc + AW'(w_off);
          r_acnt <= r_acnt + CW'(1);
          if (w_a_last) r_a_done <= 1'b1;
        end
      end
    end
  end

  assign o_freq_avg   = r_freq_avg;
  assign o_vpp_avg    = r_vpp_avg;
  assign o_offset_avg = r_offset_avg;
  assign o_no_signal  = r_no_signal;
  assign o_vld        = r_vld;
  assign o_drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_measure_result_avg.sv
// tb_measure_result_avg: directed frames with hand-computed averages; expected
// frames are queued by the stimulus and checked by a decoupled output monitor.
module tb_measure_result_avg;

  logic        clk = 1'b0;
  logic        i_rst_n;
  logic [31:0] i_freq;
  logic        i_freq_vld;
  logic [11:0] i_max_val, i_min_val;
  logic        i_amp_vld;
  logic        i_rdy;
  logic [31:0] o_freq_avg;
  logic [11:0] o_vpp_avg, o_offset_avg;
  logic        o_no_signal, o_vld;
  logic [7:0]  o_drop_cnt;

  typedef struct packed {
    logic [31:0] freq;
    logic [11:0] vpp;
    logic [11:0] off;
    logic        nosig;
  } frame_t;

  frame_t sb[$];
  int n_vec = 0;
  int n_err = 0;

  measure_result_avg #(.AVG_LOG2(3), .TIMEOUT_CYC(1000)) dut (
    .i_clk        (clk),
    .i_rst_n      (i_rst_n),
    .i_freq       (i_freq),
    .i_freq_vld   (i_freq_vld),
    .i_max_val    (i_max_val),
    .i_min_val    (i_min_val),
    .i_amp_vld    (i_amp_vld),
    .i_rdy        (i_rdy),
    .o_freq_avg   (o_freq_avg),
    .o_vpp_avg    (o_vpp_avg),
    .o_offset_avg (o_offset_avg),
    .o_no_signal  (o_no_signal),
    .o_vld        (o_vld),
    .o_drop_cnt   (o_drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every cycle a frame is presented it must match the queue head
  always @(negedge clk) begin
    if (i_rst_n === 1'b1 && o_vld === 1'b1) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_frame: got o_vld=1 expected no frame pending");
      end else begin
        check("frame_freq", 64'(o_freq_avg), 64'(sb[0].freq));
        check("frame_vpp", 64'(o_vpp_avg), 64'(sb[0].vpp));
        check("frame_offset", 64'(o_offset_avg), 64'(sb[0].off));
        check("frame_no_signal", 64'(o_no_signal), 64'(sb[0].nosig));
        if (i_rdy) void'(sb.pop_front());
      end
    end
  end

  // One cycle of stimulus; returns 1 ns after the edge that samples it
  task automatic strobe(input logic fv, input logic [31:0] f, input logic av,
                        input logic [11:0] mx, input logic [11:0] mn);
    i_freq_vld = fv;
    i_freq     = f;
    i_amp_vld  = av;
    i_max_val  = mx;
    i_min_val  = mn;
    @(posedge clk);
    #1;
    i_freq_vld = 1'b0;
    i_amp_vld  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Wait (bounded) for o_vld, then step past the next edge
  task automatic wait_vld(input int budget, input string name);
    bit got = 1'b0;
    for (int c = 0; c < budget && !got; c++) begin
      @(negedge clk);
      if (o_vld) got = 1'b1;
    end
    n_vec++;
    if (!got) begin
      n_err++;
      $display("FAIL %s: o_vld got 0 expected 1 within %0d cycles", name, budget);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst_n    = 1'b0;
    i_freq     = '0;
    i_freq_vld = 1'b0;
    i_max_val  = '0;
    i_min_val  = '0;
    i_amp_vld  = 1'b0;
    i_rdy      = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_vld", 64'(o_vld), 64'd0);
    check("rst_freq", 64'(o_freq_avg), 64'd0);
    check("rst_drop", 64'(o_drop_cnt), 64'd0);
    @(posedge clk);
    #1;
    i_rst_n = 1'b1;
    idle(2);

    // Frame 1: ramp 1000..1007 -> 1003, vpp 2000, offset 0; one-cycle valid
    sb.push_back('{32'd1003, 12'd2000, 12'd0, 1'b0});
    for (int k = 0; k < 8; k++) strobe(1'b1, 32'(1000 + k), 1'b1, 12'd1000, 12'hC18);
    @(negedge clk);
    check("lat_edge_k", 64'(o_vld), 64'd0);
    @(negedge clk);
    check("lat_edge_k1", 64'(o_vld), 64'd1);
    @(negedge clk);
    check("vld_one_cycle", 64'(o_vld), 64'd0);
    @(posedge clk);
    #1;

    // Frame 2: (100,-101) -> vpp 201, offset floor(-0.5)=-1
    sb.push_back('{32'd50, 12'd201, 12'hFFF, 1'b0});
    for (int k = 0; k < 8; k++) strobe(1'b1, 32'd50, 1'b1, 12'd100, 12'hF9B);
    wait_vld(10, "vld_frame2");

    // Frame 3: (-5,10) -> vpp clamped 0, offset 2; a 9th freq strobe is dropped
    sb.push_back('{32'd7, 12'd0, 12'd2, 1'b0});
    for (int k = 0; k < 7; k++) strobe(1'b1, 32'd7, 1'b1, 12'hFFB, 12'd10);
    strobe(1'b1, 32'd7, 1'b0, 12'd0, 12'd0);
    strobe(1'b1, 32'd1000, 1'b1, 12'hFFB, 12'd10);
    wait_vld(10, "vld_frame3");
    check("drop_after_done", 64'(o_drop_cnt), 64'd1);

    // Frame 4: no full freq set -> timeout, partial freq discarded, no_signal
    sb.push_back('{32'd0, 12'd24, 12'd8, 1'b1});
    for (int k = 0; k < 8; k++) strobe(1'b0, 32'd0, 1'b1, 12'd20, 12'hFFC);
    for (int k = 0; k < 3; k++) strobe(1'b1, 32'd999, 1'b0, 12'd0, 12'd0);
    idle(900);
    check("no_early_timeout", 64'(o_vld), 64'd0);
    wait_vld(300, "vld_timeout");

    // Frame 5: fresh freq samples clear no_signal
    sb.push_back('{32'd300, 12'd0, 12'd0, 1'b0});
    for (int k = 0; k < 8; k++) strobe(1'b1, 32'd300, 1'b1, 12'd0, 12'd0);
    wait_vld(10, "vld_frame5");

    // Frame 6: held 50 cycles with i_rdy=0, 3 freq + 2 amp strobes dropped
    i_rdy = 1'b0;
    sb.push_back('{32'd10, 12'd0, 12'd2, 1'b0});
    for (int k = 0; k < 8; k++) strobe(1'b1, 32'd10, 1'b1, 12'd2, 12'd2);
    idle(2);
    for (int c = 0; c < 50; c++) begin
      if (c == 5 || c == 20) strobe(1'b1, 32'hDEAD, 1'b1, 12'd500, 12'd0);
      else if (c == 30)      strobe(1'b1, 32'hBEEF, 1'b0, 12'd0, 12'd0);
      else                   idle(1);
    end
    check("hold_vld", 64'(o_vld), 64'd1);
    check("hold_drop_cnt", 64'(o_drop_cnt), 64'd6);
    i_rdy = 1'b1;
    idle(1);
    @(negedge clk);
    check("vld_released", 64'(o_vld), 64'd0);
    @(posedge clk);
    #1;

    // Frame 7: 7 samples are not enough; the 8th completes a fresh frame
    sb.push_back('{32'd40, 12'd10, 12'd5, 1'b0});
    for (int k = 0; k < 7; k++) strobe(1'b1, 32'd40, 1'b1, 12'd10, 12'd0);
    idle(10);
    check("partial_no_vld", 64'(o_vld), 64'd0);
    strobe(1'b1, 32'd40, 1'b1, 12'd10, 12'd0);
    wait_vld(10, "vld_frame7");

    // Frame 8: full-scale same-cycle strobes, no overflow
    sb.push_back('{32'hFFFF_FFFF, 12'd4095, 12'hFFF, 1'b0});
    for (int k = 0; k < 8; k++) strobe(1'b1, 32'hFFFF_FFFF, 1'b1, 12'd2047, 12'h800);
    wait_vld(10, "vld_frame8");
    check("drop_unchanged", 64'(o_drop_cnt), 64'd6);

    // Reset after 5 samples: outputs clear, partial sums lost
    for (int k = 0; k < 5; k++) strobe(1'b1, 32'd5000, 1'b1, 12'd1000, 12'd0);
    i_rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_freq", 64'(o_freq_avg), 64'd0);
    check("mid_rst_vpp", 64'(o_vpp_avg), 64'd0);
    check("mid_rst_offset", 64'(o_offset_avg), 64'd0);
    check("mid_rst_vld", 64'(o_vld), 64'd0);
    check("mid_rst_drop", 64'(o_drop_cnt), 64'd0);
    @(posedge clk);
    #1;
    i_rst_n = 1'b1;
    idle(1);
    sb.push_back('{32'd60, 12'd20, 12'd20, 1'b0});
    for (int k = 0; k < 8; k++) strobe(1'b1, 32'd60, 1'b1, 12'd30, 12'd10);
    wait_vld(10, "vld_post_reset");
    check("post_rst_drop", 64'(o_drop_cnt), 64'd0);
    idle(3);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/measure_result_avg.md
Name: measure_result_avg

Overview:
Post-processing stage that consumes raw measurement results from the measurement top: frequency words and max/min amplitude pairs. It block-averages 2^AVG_LOG2 results of each kind and derives peak-to-peak and DC-offset values. It presents one stable result frame to the display/UART layer under a valid/ready handshake. It also flags loss of input signal via a frequency timeout.

Parameters:
AVG_LOG2, 3, log2 of the number of samples averaged per frame (N = 8 by default); legal values 0..8.
TIMEOUT_CYC, 100_000_000, i_clk cycles without i_freq_vld before the frequency is declared absent; minimum 2.

Ports:
i_clk  in  1  system clock; all inputs are synchronous to it (upstream performs CDC).
i_rst_n  in  1  asynchronous active-low reset.
i_freq  in  32  measured frequency, unsigned.
i_freq_vld  in  1  single-cycle strobe qualifying i_freq.
i_max_val  in  12  signed peak maximum.
i_min_val  in  12  signed peak minimum.
i_amp_vld  in  1  single-cycle strobe qualifying i_max_val/i_min_val.
i_rdy  in  1  consumer ready.
o_freq_avg  out  32  averaged frequency, unsigned.
o_vpp_avg  out  12  averaged peak-to-peak, unsigned.
o_offset_avg  out  12  averaged midpoint (max+min)/2, signed.
o_no_signal  out  1  frame frequency forced to 0 by timeout.
o_vld  out  1  frame valid.
o_drop_cnt  out  8  count of samples discarded while a frame was pending; saturates at 255.

Behaviour:
- Reset (async, i_rst_n=0):
  - All outputs 0; accumulators, counters and done flags cleared; state COLLECT.
  - Reset mid-frame discards the partial sums; no frame is emitted.
- States: COLLECT and OUTPUT.
- COLLECT, frequency path:
  - On i_freq_vld, facc += i_freq. facc is 32+AVG_LOG2 bits, so it cannot overflow.
  - The sample counter fcnt increments; when the N-th sample is accepted, f_done=1.
  - freq result = facc_total >> AVG_LOG2, truncated.
  - Strobes arriving after f_done=1 and before frame transfer are dropped and counted.
- COLLECT, amplitude path:
  - vpp = i_max_val - i_min_val, computed in 13-bit signed, clamped to 0 if negative, then stored as 12-bit unsigned. Range 0..4095.
  - off = (i_max_val + i_min_val) >>> 1, computed with a 13-bit signed sum and an arithmetic shift.
  - Accumulators: vacc is unsigned and oacc is signed, each 13+AVG_LOG2 bits.
  - On the N-th i_amp_vld, a_done=1.
  - Results: vacc >> AVG_LOG2 and oacc >>> AVG_LOG2. The signed offset result is floor-rounded (toward -inf).
  - Post-done strobes are dropped and counted.
- i_freq_vld and i_amp_vld in the same cycle: both are accepted independently.
- Timeout:
  - tcnt counts cycles in COLLECT while f_done=0, and clears on every i_freq_vld.
  - When tcnt reaches TIMEOUT_CYC-1: frequency result=0, no_signal flag=1, f_done=1, and partial facc is discarded.
  - A timeout in the same cycle as the N-th i_freq_vld: the sample wins and no_signal=0.
- Transfer:
  - Cycle in which f_done and a_done are both 1: the output registers are loaded from the results and o_no_signal is loaded from the flag.
  - o_vld=1 from the next edge; state becomes OUTPUT.
  - Latency: last completing strobe at edge k -> done at k -> o_vld visible after edge k+1.
- OUTPUT:
  - o_vld and all o_* data are held stable until an edge with i_rdy=1.
  - On that edge o_vld=0, accumulators, flags and tcnt are cleared, and the state returns to COLLECT.
  - i_rdy with o_vld=0 has no effect.
  - Any strobe in OUTPUT, including the handshake edge, is dropped.
- Drop counting:
  - Each dropped strobe adds 1 to o_drop_cnt.
  - Two drops in one cycle add 2, saturating at 255.
  - o_drop_cnt is cleared only by reset.
- Data outputs retain the last frame while o_vld=0.

Test Plan:
- Defaults, 8 freq strobes 1000..1007 and 8 amp pairs (1000,-1000), i_rdy=1 -> one frame: o_freq_avg=1003, o_vpp_avg=2000, o_offset_avg=0, o_no_signal=0; o_vld high for exactly 1 cycle, asserted one edge after the last strobe.
- 8 amp pairs (100,-101), 8 freq=50 -> o_offset_avg=-1 (floor), o_vpp_avg=201, o_freq_avg=50; pairs (-5,10) -> vpp clamped 0, offset 2.
- TIMEOUT_CYC=1000, no i_freq_vld, 8 amp pairs -> frame after the timeout with o_freq_avg=0, o_no_signal=1; next frame with 8 freq strobes clears o_no_signal.
- i_rdy=0 for 50 cycles after o_vld, 3 freq + 2 amp strobes injected -> outputs stable, o_drop_cnt=5; after i_rdy=1, o_vld drops and the next frame needs a fresh 8+8.
- Same-cycle freq/amp strobes x8 with max values (0xFFFFFFFF, 2047/-2048) -> o_freq_avg=0xFFFFFFFF, o_vpp_avg=4095, no overflow.
- Assert i_rst_n=0 after 5 of 8 samples, release, supply 8+8 -> outputs 0 during reset; first frame reflects only post-reset samples.
